ice40_spi_master_burst: RTL and testbench

//  Parametrised SB_SPI hard-IP master driver. Programs the iCE40 SPI block at reset, then runs

---
 rtl/ice40_spi_master_burst_if.sv | 31 +++
 rtl/ice40_spi_master_burst.sv | 218 +++++++++++++++++++++
 tb/tb_ice40_spi_master_burst.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ice40_spi_master_burst_if.sv
// User byte stream plus SB_SPI system-bus signals for the SPI burst master.
// The master modport is the driver's view; slave is the user logic / SB_SPI side.
interface ice40_spi_master_burst_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic [1:0] cs_sel;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       timeout_err;
  logic [7:0] spi_data_out;
  logic       spi_ack;
  logic       spi_rw;
  logic [7:0] spi_reg_addr;
  logic       spi_strobe;
  logic [7:0] spi_data_in;

  modport master (
    input  tx_valid, tx_data, tx_last, cs_sel, spi_data_out, spi_ack,
    output tx_ready, rx_valid, rx_data, busy, timeout_err,
           spi_rw, spi_reg_addr, spi_strobe, spi_data_in
  );

  modport slave (
    output tx_valid, tx_data, tx_last, cs_sel, spi_data_out, spi_ack,
    input  tx_ready, rx_valid, rx_data, busy, timeout_err,
           spi_rw, spi_reg_addr, spi_strobe, spi_data_in
  );
endinterface

// File: rtl/ice40_spi_master_burst.sv
// SB_SPI hard-IP master driver: programs the block after reset, then runs
// full-duplex byte bursts with chip-select held across bytes.
module ice40_spi_master_burst #(
  parameter int unsigned SPI_CLK_DIVIDER = 0,
  parameter int unsigned CPOL            = 0,
  parameter int unsigned CPHA            = 0,
  parameter int unsigned LSB_FIRST       = 0,
  parameter int unsigned NUM_CS          = 1,
  parameter int unsigned POLL_TIMEOUT    = 1023
) (
  input logic                    clk,
  input logic                    reset,
  ice40_spi_master_burst_if.master bus
);

  // SB_SPI register map, instance 0 (SBADRI[7:4] = 4'b0000)
  localparam logic [7:0] ADDR_CR0  = 8'h08;
  localparam logic [7:0] ADDR_CR1  = 8'h09;
  localparam logic [7:0] ADDR_CR2  = 8'h0A;
  localparam logic [7:0] ADDR_BR   = 8'h0B;
  localparam logic [7:0] ADDR_SR   = 8'h0C;
  localparam logic [7:0] ADDR_TXDR = 8'h0D;
  localparam logic [7:0] ADDR_RXDR = 8'h0E;
  localparam logic [7:0] ADDR_CSR  = 8'h0F;

  localparam logic [7:0] CR2_VAL = {3'b110, 2'b00, 1'(CPOL), 1'(CPHA), 1'(LSB_FIRST)};
  localparam logic [7:0] BR_VAL  = {2'b00, 6'(SPI_CLK_DIVIDER)};
  localparam logic [3:0] CS_MASK = 4'((1 << NUM_CS) - 1);
  localparam int unsigned PW     = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_TIMEOUT - 1);

  typedef enum logic [3:0] {
    INIT_CR0, INIT_CR1, INIT_CR2, INIT_BR, INIT_CSR, IDLE, SEL_CS,
    POLL_TRDY, WR_TXDR, POLL_RRDY, RD_RXDR, BURST_WAIT, DESEL_CS
  } state_t;

  state_t        state_q, state_nxt;
  logic          strobe_q, strobe_nxt, rw_q, rw_nxt;
  logic [7:0]    addr_q, addr_nxt, wdata_q, wdata_nxt;
  logic          tx_ready_q, tx_ready_nxt, rx_valid_q, rx_valid_nxt;
  logic [7:0]    rx_data_q, rx_data_nxt;
  logic          busy_q, busy_nxt, timeout_q, timeout_nxt;
  logic [7:0]    byte_q, byte_nxt;
  logic          last_q, last_nxt;
  logic [1:0]    cs_q, cs_nxt;
  logic [PW-1:0] poll_q, poll_nxt;

  logic          acc_req, acc_rw, acc_done, accept;
  logic [7:0]    acc_addr, acc_data;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= INIT_CR0;
      strobe_q   <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      busy_q     <= 1'b1;
      timeout_q  <= 1'b0;
      byte_q     <= 8'h00;
      last_q     <= 1'b0;
      cs_q       <= 2'd0;
      poll_q     <= '0;
    end else begin
      state_q    <= state_nxt;
      strobe_q   <= strobe_nxt;
      rw_q       <= rw_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
      tx_ready_q <= tx_ready_nxt;
      rx_valid_q <= rx_valid_nxt;
      rx_data_q  <= rx_data_nxt;
      busy_q     <= busy_nxt;
      timeout_q  <= timeout_nxt;
      byte_q     <= byte_nxt;
      last_q     <= last_nxt;
      cs_q       <= cs_nxt;
      poll_q     <= poll_nxt;
    end
  end

  // Each bus state names one access; the shared strobe logic below runs it.
  always_comb begin
    state_nxt    = state_q;
    strobe_nxt   = strobe_q;
    rw_nxt       = rw_q;
    addr_nxt     = addr_q;
    wdata_nxt    = wdata_q;
    rx_valid_nxt = 1'b0;
    rx_data_nxt  = rx_data_q;
    timeout_nxt  = timeout_q;
    byte_nxt     = byte_q;
    last_nxt     = last_q;
    cs_nxt       = cs_q;
    poll_nxt     = poll_q;
    acc_req      = 1'b0;
    acc_rw       = 1'b0;
    acc_addr     = 8'h00;
    acc_data     = 8'h00;
    acc_done     = strobe_q && bus.spi_ack;
    accept       = tx_ready_q && bus.tx_valid;

    case (state_q)
      INIT_CR0: begin
        acc_req = 1'b1; acc_rw = 1'b1; acc_addr = ADDR_CR0; acc_data = 8'h00;
        if (acc_done) state_nxt = INIT_CR1;
      end
      INIT_CR1: begin
        acc_req = 1'b1; acc_rw = 1'b1; acc_addr = ADDR_CR1; acc_data = 8'h80;
        if (acc_done) state_nxt = INIT_CR2;
      end
      INIT_CR2: begin
        acc_req = 1'b1; acc_rw = 1'b1; acc_addr = ADDR_CR2; acc_data = CR2_VAL;
        if (acc_done) state_nxt = INIT_BR;
      end
      INIT_BR: begin
        acc_req = 1'b1; acc_rw = 1'b1; acc_addr = ADDR_BR; acc_data = BR_VAL;
        if (acc_done) state_nxt = INIT_CSR;
      end
      INIT_CSR: begin
        acc_req = 1'b1; acc_rw = 1'b1; acc_addr = ADDR_CSR; acc_data = 8'h00;
        if (acc_done) state_nxt = IDLE;
      end
      IDLE: begin
        if (accept) begin
          byte_nxt    = bus.tx_data;
          last_nxt    = bus.tx_last;
          cs_nxt      = bus.cs_sel;
          timeout_nxt = 1'b0;
          state_nxt   = SEL_CS;
        end
      end
      SEL_CS: begin
        acc_req = 1'b1; acc_rw = 1'b1; acc_addr = ADDR_CSR;
        acc_data = {4'b0000, (4'b0001 << cs_q) & CS_MASK};
        if (acc_done) state_nxt = POLL_TRDY;
      end
      POLL_TRDY: begin
        acc_req = 1'b1; acc_addr = ADDR_SR;
        if (acc_done) begin
          if (bus.spi_data_out[4]) state_nxt = WR_TXDR;
          else if (poll_q == POLL_LAST) begin
            timeout_nxt = 1'b1;
            state_nxt   = DESEL_CS;
          end else poll_nxt = poll_q + 1'b1;
        end
      end
      WR_TXDR: begin
        acc_req = 1'b1; acc_rw = 1'b1; acc_addr = ADDR_TXDR; acc_data = byte_q;
        if (acc_done) state_nxt = POLL_RRDY;
      end
      POLL_RRDY: begin
        acc_req = 1'b1; acc_addr = ADDR_SR;
        if (acc_done) begin
          if (bus.spi_data_out[3]) state_nxt = RD_RXDR;
          else if (poll_q == POLL_LAST) begin
            timeout_nxt = 1'b1;
            state_nxt   = DESEL_CS;
          end else poll_nxt = poll_q + 1'b1;
        end
      end
      RD_RXDR: begin
        acc_req = 1'b1; acc_addr = ADDR_RXDR;
        if (acc_done) begin
          rx_data_nxt  = bus.spi_data_out;
          rx_valid_nxt = 1'b1;
          state_nxt    = last_q ? DESEL_CS : BURST_WAIT;
        end
      end
      BURST_WAIT: begin
        if (accept) begin
          byte_nxt  = bus.tx_data;
          last_nxt  = bus.tx_last;
          state_nxt = POLL_TRDY;
        end
      end
      DESEL_CS: begin
        acc_req = 1'b1; acc_rw = 1'b1; acc_addr = ADDR_CSR; acc_data = 8'h00;
        if (acc_done) state_nxt = IDLE;
      end
      default: state_nxt = INIT_CR0;
    endcase

    // Strobe rises only from a low cycle, so consecutive accesses get a gap
    if (acc_req) begin
      if (!strobe_q) begin
        strobe_nxt = 1'b1;
        rw_nxt     = acc_rw;
        addr_nxt   = acc_addr;
        wdata_nxt  = acc_data;
      end else if (bus.spi_ack) begin
        strobe_nxt = 1'b0;
      end
    end else begin
      strobe_nxt = 1'b0;
    end

    if (state_q != POLL_TRDY && state_q != POLL_RRDY) poll_nxt = '0;

    tx_ready_nxt = (state_nxt == IDLE || state_nxt == BURST_WAIT) && !rx_valid_nxt;
    busy_nxt     = (state_nxt != IDLE);
  end

  assign bus.spi_strobe   = strobe_q;
  assign bus.spi_rw       = rw_q;
  assign bus.spi_reg_addr = addr_q;
  assign bus.spi_data_in  = wdata_q;
  assign bus.tx_ready     = tx_ready_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.busy         = busy_q;
  assign bus.timeout_err  = timeout_q;

endmodule

// File: tb/tb_ice40_spi_master_burst.sv
// Directed bench for ice40_spi_master_burst: SB_SPI bus model plus scoreboards
// for expected register accesses and received bytes.
module tb_ice40_spi_master_burst;

  localparam logic [7:0] A_CR0 = 8'h08, A_CR1 = 8'h09, A_CR2 = 8'h0A, A_BR = 8'h0B;
  localparam logic [7:0] A_SR = 8'h0C, A_TXDR = 8'h0D, A_RXDR = 8'h0E, A_CSR = 8'h0F;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  ice40_spi_master_burst_if bus ();

  ice40_spi_master_burst #(
    .SPI_CLK_DIVIDER(3), .CPOL(1), .CPHA(0), .LSB_FIRST(1),
    .NUM_CS(4), .POLL_TIMEOUT(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // {rw, addr, write data or 0 for reads}
  logic [16:0] exp_bus_q[$];
  logic [7:0]  exp_rx_q[$];

  int         ack_delay = 1;
  logic       sr_trdy = 1'b1;
  logic       sr_rrdy = 1'b1;
  logic [7:0] rx_xor  = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_w(input logic [7:0] a, input logic [7:0] d);
    exp_bus_q.push_back({1'b1, a, d});
  endtask

  task automatic push_r(input logic [7:0] a);
    exp_bus_q.push_back({1'b0, a, 8'h00});
  endtask

  task automatic push_init();
    push_w(A_CR0, 8'h00); push_w(A_CR1, 8'h80); push_w(A_CR2, 8'hC5);
    push_w(A_BR, 8'h03);  push_w(A_CSR, 8'h00);
  endtask

  task automatic push_byte(input logic [7:0] d);
    push_r(A_SR); push_w(A_TXDR, d); push_r(A_SR); push_r(A_RXDR);
    exp_rx_q.push_back(d ^ rx_xor);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input logic [1:0] c);
    int n = 0;
    @(negedge clk);
    while (!bus.tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("tx_ready_wait", 32'(bus.tx_ready), 32'd1);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    bus.tx_last  = l;
    bus.cs_sel   = c;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int  n = 0;
    bit  ok = 1'b0;
    while (n < 2000 && !ok) begin
      @(negedge clk);
      ok = !bus.busy && bus.tx_ready && exp_bus_q.size() == 0 && exp_rx_q.size() == 0;
      n++;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out"}, {bus.spi_strobe, bus.spi_rw, bus.spi_reg_addr, bus.spi_data_in,
                        bus.tx_ready, bus.rx_valid, bus.timeout_err, bus.busy, 4'h0, 1'b0},
        {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0});
    chk({tag, "_rx_data"}, 32'(bus.rx_data), 32'h0);
  endtask

  // SB_SPI model and output monitors, sampled on the falling edge
  initial begin : spi_model
    int          cnt = 0;
    logic [16:0] cur, cap, e;
    logic [7:0]  last_tx = 8'h00;
    bus.spi_ack      = 1'b0;
    bus.spi_data_out = 8'h00;
    cap = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bus.spi_ack = 1'b0;
        cnt = 0;
      end else begin
        if (bus.spi_ack) begin
          chk("strobe_drop", 32'(bus.spi_strobe), 32'd0);
          bus.spi_ack = 1'b0;
          cnt = 0;
        end else if (bus.spi_strobe) begin
          cur = {bus.spi_rw, bus.spi_reg_addr, bus.spi_rw ? bus.spi_data_in : 8'h00};
          if (cnt == 0) cap = cur;
          else chk("bus_hold", 32'(cur), 32'(cap));
          cnt++;
          if (cnt >= ack_delay) begin
            chk("bus_pending", 32'(exp_bus_q.size() > 0), 32'd1);
            if (exp_bus_q.size() > 0) begin
              e = exp_bus_q.pop_front();
              chk("bus_access", 32'(cur), 32'(e));
            end
            if (bus.spi_rw && bus.spi_reg_addr == A_TXDR) last_tx = bus.spi_data_in;
            if (bus.spi_reg_addr == A_SR) bus.spi_data_out = {3'b000, sr_trdy, sr_rrdy, 3'b000};
            else if (bus.spi_reg_addr == A_RXDR) bus.spi_data_out = last_tx ^ rx_xor;
            else bus.spi_data_out = 8'h00;
            bus.spi_ack = 1'b1;
          end
        end
        if (bus.rx_valid) begin
          chk("rx_pending", 32'(exp_rx_q.size() > 0), 32'd1);
          chk("rx_vs_tx_ready", 32'(bus.tx_ready), 32'd0);
          if (exp_rx_q.size() > 0) chk("rx_data", 32'(bus.rx_data), 32'(exp_rx_q.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    reset        = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_last  = 1'b0;
    bus.cs_sel   = 2'd0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");

    // Init sequence
    push_init();
    reset = 1'b0;
    wait_done("init_done");
    chk("init_busy", 32'(bus.busy), 32'd0);
    chk("init_tx_ready", 32'(bus.tx_ready), 32'd1);

    // Single byte, RXDR returns 0x3C
    rx_xor = 8'hA5 ^ 8'h3C;
    push_w(A_CSR, 8'h01); push_byte(8'hA5); push_w(A_CSR, 8'h00);
    send_byte(8'hA5, 1'b1, 2'd0);
    wait_done("single_done");
    chk("single_timeout", 32'(bus.timeout_err), 32'd0);

    // Three-byte gapped burst on CS2; later cs_sel values must be ignored
    rx_xor = 8'hFF;
    push_w(A_CSR, 8'h04);
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    push_w(A_CSR, 8'h00);
    send_byte(8'h01, 1'b0, 2'd2);
    repeat (20) @(negedge clk);
    chk("burst_busy", 32'(bus.busy), 32'd1);
    send_byte(8'h02, 1'b0, 2'd3);
    repeat (20) @(negedge clk);
    send_byte(8'h03, 1'b1, 2'd1);
    wait_done("burst_done");

    // TRDY never set: four SR reads, abort, deselect
    sr_trdy = 1'b0;
    push_w(A_CSR, 8'h01);
    repeat (4) push_r(A_SR);
    push_w(A_CSR, 8'h00);
    send_byte(8'h55, 1'b1, 2'd0);
    wait_done("timeout_done");
    chk("timeout_set", 32'(bus.timeout_err), 32'd1);
    sr_trdy = 1'b1;
    push_w(A_CSR, 8'h02); push_byte(8'h66); push_w(A_CSR, 8'h00);
    send_byte(8'h66, 1'b1, 2'd1);
    chk("timeout_clear", 32'(bus.timeout_err), 32'd0);
    wait_done("after_timeout_done");

    // Slow ack: every access held for five cycles
    ack_delay = 5;
    rx_xor = 8'h99;
    push_w(A_CSR, 8'h01); push_byte(8'h5A); push_w(A_CSR, 8'h00);
    send_byte(8'h5A, 1'b1, 2'd0);
    wait_done("slow_done");
    ack_delay = 1;

    // Reset while polling RRDY
    sr_rrdy = 1'b0;
    push_w(A_CSR, 8'h01); push_r(A_SR); push_w(A_TXDR, 8'h77); push_r(A_SR);
    send_byte(8'h77, 1'b1, 2'd0);
    n = 0;
    while (exp_bus_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("rrdy_poll_reached", 32'(exp_bus_q.size()), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    sr_rrdy = 1'b1;
    @(negedge clk);
    push_init();
    reset = 1'b0;
    wait_done("reinit_done");

    // Normal traffic after re-init
    rx_xor = 8'h0F;
    push_w(A_CSR, 8'h08); push_byte(8'h81); push_w(A_CSR, 8'h00);
    send_byte(8'h81, 1'b1, 2'd3);
    wait_done("final_done");
    chk("final_timeout", 32'(bus.timeout_err), 32'd0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
